// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered 8N1 UART transmitter with optional even/odd parity
module uart_tx_fifo #(
  parameter int BAUD_DIV   = 10417,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY     = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    d_tx,
  input  logic                          vld_tx,
  output logic                          rdy_tx,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] B_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t state, nxt_state;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [BW-1:0] baud;
  logic [2:0] bit_idx;
  logic [7:0] shift, nxt_shift;
  logic par, nxt_par, nxt_txd, bnd, push, pop;
  assign rdy_tx = count != FULL;
  assign busy = state != IDLE || count != '0;
  assign frame_done = state == STOP && bnd;
  // next state, pop decision and the value txd will carry after this edge
  always_comb begin
    bnd = baud == B_LAST;
    push = vld_tx && rdy_tx;
    pop = (state == IDLE || (state == STOP && bnd)) && count != '0;
    nxt_state = state;
    case (state)
      IDLE:    nxt_state = count != '0 ? START : IDLE;
      START:   nxt_state = bnd ? DATA : START;
      DATA:    nxt_state = bnd && bit_idx == 3'd7 ? (PARITY != 0 ? PAR : STOP) : DATA;
      PAR:     nxt_state = bnd ? STOP : PAR;
      STOP:    nxt_state = bnd ? (count != '0 ? START : IDLE) : STOP;
      default: nxt_state = IDLE;
    endcase
    nxt_shift = pop ? mem[rp] : state == DATA && bnd ? shift >> 1 : shift;
    nxt_par = pop ? ^mem[rp] ^ (PARITY == 2) : par;
    nxt_txd = nxt_state == START ? 1'b0 : nxt_state == DATA ? nxt_shift[0] : nxt_state == PAR ? nxt_par : 1'b1;
  end
  // FIFO storage; stale writes during reset are harmless since pointers clear
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= d_tx;
  end
  // state, baud timing, shifter, FIFO pointers/count and registered txd
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      count <= '0;
      baud <= '0;
      bit_idx <= '0;
      shift <= '0;
      par <= 1'b0;
      txd <= 1'b1;
    end else begin
      state <= nxt_state;
      baud <= (nxt_state != state || state == IDLE || bnd) ? '0 : baud + 1'b1;
      bit_idx <= pop ? '0 : state == DATA && bnd ? bit_idx + 3'd1 : bit_idx;
      shift <= nxt_shift;
      par <= nxt_par;
      txd <= nxt_txd;
      wp <= push ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: checks three parity variants against a frame-timer reference model
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic rst, vld_tx;
  logic [7:0] d_tx;
  logic txd_o [3];
  logic rdy_o [3];
  logic busy_o [3];
  logic fd_o [3];
  logic [2:0] cnt_o [3];
  int cyc = 0, total = 0, passes = 0, fails = 0;
  int mn [3], mh [3], mt [3];
  bit mact [3];
  logic [7:0] mq [3][4];
  logic [7:0] mcur [3];

  always #5 clk = ~clk;

  uart_tx_fifo #(.BAUD_DIV(4), .FIFO_DEPTH(4), .PARITY(0)) u0 (.clk(clk), .rst(rst), .d_tx(d_tx), .vld_tx(vld_tx),
    .rdy_tx(rdy_o[0]), .txd(txd_o[0]), .busy(busy_o[0]), .count(cnt_o[0]), .frame_done(fd_o[0]));
  uart_tx_fifo #(.BAUD_DIV(4), .FIFO_DEPTH(4), .PARITY(1)) u1 (.clk(clk), .rst(rst), .d_tx(d_tx), .vld_tx(vld_tx),
    .rdy_tx(rdy_o[1]), .txd(txd_o[1]), .busy(busy_o[1]), .count(cnt_o[1]), .frame_done(fd_o[1]));
  uart_tx_fifo #(.BAUD_DIV(4), .FIFO_DEPTH(4), .PARITY(2)) u2 (.clk(clk), .rst(rst), .d_tx(d_tx), .vld_tx(vld_tx),
    .rdy_tx(rdy_o[2]), .txd(txd_o[2]), .busy(busy_o[2]), .count(cnt_o[2]), .frame_done(fd_o[2]));

  function automatic int flen(input int k);
    return k == 0 ? 40 : 44;
  endfunction

  function automatic logic exp_txd(input int k);
    int b;
    if (!mact[k]) return 1'b1;
    b = mt[k] / 4;
    if (b == 0) return 1'b0;
    if (b <= 8) return mcur[k][b-1];
    if (k != 0 && b == 9) return ^mcur[k] ^ (k == 2);
    return 1'b1;
  endfunction

  task automatic model_edge(input int k);
    bit ending, start, acc;
    if (rst) begin
      mn[k] = 0; mh[k] = 0; mact[k] = 0; mt[k] = 0;
      return;
    end
    ending = mact[k] && mt[k] == flen(k) - 1;
    start = (!mact[k] || ending) && mn[k] > 0;
    acc = vld_tx && mn[k] < 4;
    if (mact[k]) mt[k]++;
    if (ending) mact[k] = 0;
    if (start) begin
      mcur[k] = mq[k][mh[k]];
      mh[k] = (mh[k] + 1) % 4;
      mn[k]--;
      mact[k] = 1;
      mt[k] = 0;
    end
    if (acc) begin
      mq[k][(mh[k] + mn[k]) % 4] = d_tx;
      mn[k]++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] d);
    rst = r; vld_tx = v; d_tx = d;
    for (int k = 0; k < 3; k++) model_edge(k);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk($sformatf("p%0d_outs{txd,rdy,busy,fd,count}", k),
          {txd_o[k], rdy_o[k], busy_o[k], fd_o[k], cnt_o[k]},
          {exp_txd(k), mn[k] != 4, mact[k] || mn[k] != 0, mact[k] && mt[k] == flen(k) - 1, 3'(mn[k])});
  endtask

  initial begin
    int fd [3];
    int bz;
    rst = 1'b1; vld_tx = 1'b0; d_tx = 8'h00;
    repeat (3) step(1'b1, 1'b1, 8'hFF);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h55);
    fd = '{-1, -1, -1};
    bz = -1;
    for (int i = 1; i <= 50; i++) begin
      step(1'b0, 1'b0, 8'h00);
      for (int k = 0; k < 3; k++) if (fd_o[k] && fd[k] < 0) fd[k] = i;
      if (!busy_o[0] && bz < 0) bz = i;
    end
    chk("p0_frame_done_latency", fd[0], 40);
    chk("p1_frame_done_latency", fd[1], 44);
    chk("p0_busy_fall", bz, 41);
    step(1'b0, 1'b1, 8'h07);
    fd = '{-1, -1, -1};
    for (int i = 1; i <= 50; i++) begin
      step(1'b0, 1'b0, 8'h00);
      if (i == 38) begin
        chk("even_parity_bit_07", txd_o[1], 1'b1);
        chk("odd_parity_bit_07", txd_o[2], 1'b0);
      end
      for (int k = 0; k < 3; k++) if (fd_o[k] && fd[k] < 0) fd[k] = i;
    end
    chk("p2_frame_done_latency", fd[2], 44);
    step(1'b0, 1'b1, 8'hA5);
    step(1'b0, 1'b1, 8'h3C);
    step(1'b0, 1'b1, 8'h00);
    chk("b2b_count_after_pushes", cnt_o[0], 3'd2);
    repeat (140) step(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h10 + 8'(i));
    chk("overflow_count_full", cnt_o[0], 3'd4);
    chk("overflow_rdy_low", rdy_o[0], 1'b0);
    repeat (250) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hC3);
    step(1'b0, 1'b1, 8'h11);
    step(1'b0, 1'b1, 8'h22);
    for (int i = 3; i < 18; i++) step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    chk("midframe_reset_txd", txd_o[0], 1'b1);
    chk("midframe_reset_count", cnt_o[0], 3'd0);
    repeat (60) step(1'b0, 1'b0, 8'h00);
    chk("after_reset_idle_busy", busy_o[0], 1'b0);
    for (int i = 0; i < 1500; i++)
      step($urandom_range(399) == 0, $urandom_range(2) == 0, 8'($urandom));
    repeat (300) step(1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) chk($sformatf("p%0d_drained_busy", k), busy_o[k], 1'b0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
